// File: rtl/fifo_wr_arbiter.sv
`timescale 1ns/1ps
// Purpose : round-robin sharing of one async_fifo write port among NUM_REQ producers.
// Latency : one arbitration cycle from IDLE to first write; back-to-back owner switches add none.
// Backpr. : full stalls the current owner in place (no write, no ack, burst count held).
//
// Ports:
//   wr_clk   - write-domain clock, all state on its rising edge
//   rst      - synchronous active-high reset; forces all outputs to 0 in that cycle
//   req      - per-producer "word available"; held until ack, dropping it ends a grant
//   req_data - producer i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   ack      - one-hot, producer's word is written at this edge
//   full     - async_fifo full flag
//   wr_en    - async_fifo write enable
//   wr_data  - async_fifo write data (owner's word while granted, else 0)
//   grant_id - current owner index (0 when not busy)
//   busy     - high while a producer holds the grant
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          wr_clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          full,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BCW = $clog2(MAX_BURST + 1);
  localparam logic [IDW-1:0] LAST_IDX   = IDW'(NUM_REQ - 1);
  localparam logic [BCW-1:0] BURST_LAST = BCW'(MAX_BURST - 1);
  localparam logic [BCW-1:0] BURST_MAX  = BCW'(MAX_BURST);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] owner, owner_nxt;
  logic [IDW-1:0] last_owner, last_owner_nxt;
  logic [BCW-1:0] burst_cnt, burst_cnt_nxt;
  logic [NUM_REQ-1:0] others;
  logic           end_grant;

  // Per-producer view of the flattened data bus.
  logic [DATA_WIDTH-1:0] words [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign words[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // First set bit of mask scanning after+1, after+2, ... with wrap-around.
  // The wrap is done explicitly so NUM_REQ need not be a power of two.
  function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                             input logic [IDW-1:0]     after);
    logic [IDW-1:0] idx;
    logic [IDW-1:0] pick;
    logic           found;
    idx   = after;
    pick  = after;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
      if (!found && mask[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= LAST_IDX;  // gives req[0] first priority after reset
      burst_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      burst_cnt  <= burst_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    burst_cnt_nxt  = burst_cnt;
    wr_en          = 1'b0;
    ack            = '0;
    wr_data        = '0;
    grant_id       = '0;
    busy           = 1'b0;
    end_grant      = 1'b0;
    // Competitors for a back-to-back switch: the outgoing owner is excluded
    // so a still-requesting owner only wins again via IDLE.
    others         = req;
    others[owner]  = 1'b0;

    unique case (state)
      IDLE: begin
        if (|req) begin
          owner_nxt     = rr_pick(req, last_owner);
          burst_cnt_nxt = '0;
          state_nxt     = GRANT;
        end
      end

      GRANT: begin
        busy       = 1'b1;
        grant_id   = owner;
        wr_data    = words[owner];
        wr_en      = req[owner] & ~full;
        ack[owner] = wr_en;

        end_grant = (wr_en && (burst_cnt == BURST_LAST)) || !req[owner];

        if (end_grant) begin
          last_owner_nxt = owner;
          burst_cnt_nxt  = '0;
          if (|others) begin
            owner_nxt = rr_pick(others, owner);
          end else begin
            state_nxt = IDLE;
          end
        end else if (wr_en) begin
          burst_cnt_nxt = burst_cnt + 1'b1;
        end
        // else: full stall, owner and burst_cnt held
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Reset cycle: nothing leaves the block even if a grant was active.
    if (rst) begin
      wr_en    = 1'b0;
      ack      = '0;
      wr_data  = '0;
      grant_id = '0;
      busy     = 1'b0;
    end
  end

  a_no_write_when_full : assert property (@(posedge wr_clk) !(wr_en && full));
  a_ack_onehot         : assert property (@(posedge wr_clk) $onehot0(ack));
  a_ack_matches_wr_en  : assert property (@(posedge wr_clk) (|ack) == wr_en);
  a_burst_bounded      : assert property (@(posedge wr_clk) disable iff (rst) burst_cnt <= BURST_MAX);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int MAXB = 4;
  localparam int GW   = 2;

  logic                 wr_clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      ack;
  logic                 full;
  logic                 wr_en;
  logic [DW-1:0]        wr_data;
  logic [GW-1:0]        grant_id;
  logic                 busy;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NREQ), .MAX_BURST(MAXB)) dut (
    .wr_clk  (wr_clk),
    .rst     (rst),
    .req     (req),
    .req_data(req_data),
    .ack     (ack),
    .full    (full),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .grant_id(grant_id),
    .busy    (busy)
  );

  always #5 wr_clk = ~wr_clk;

  int vectors    = 0;
  int miscompares = 0;

  // Table vectors: {inputs, expected outputs}
  typedef struct {
    logic            rst;
    logic [NREQ-1:0] req;
    logic            full;
    logic            wr_en;
    logic [NREQ-1:0] ack;
    logic            busy;
    logic [GW-1:0]   gid;
  } vec_t;
  vec_t tbl [25];

  // Producers: word lists, consumption pointer (on ack), scoreboard pointer (on write)
  logic [7:0] pmem [NREQ][64];
  int  phead [NREQ];
  int  ptail [NREQ];
  int  shead [NREQ];
  bit  hold  [NREQ];
  bit  rand_gaps;

  // Write log for timing/order checks
  int         wlog_id  [256];
  int         wlog_cyc [256];
  logic [7:0] wlog_dat [256];
  int         nlog;
  int         cyc;

  // Reference model: -1 = nobody granted
  int m_cur, m_prev, m_taken;

  int exp2_cyc [6] = '{1, 2, 3, 4, 6, 7};
  int exp4_cyc [5] = '{1, 5, 6, 7, 9};
  int exp6_cyc [3] = '{1, 4, 5};

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int rr_next(input int prev, input logic [NREQ-1:0] mask);
    int j;
    for (int k = 1; k <= NREQ; k++) begin
      j = (prev + k) % NREQ;
      if (mask[j]) return j;
    end
    return -1;
  endfunction

  // One clock of the producer/model/scoreboard engine.
  task automatic step_cycle(input bit r, input bit f);
    logic [NREQ-1:0]    rq;
    logic [NREQ*DW-1:0] rd;
    logic [NREQ-1:0]    eack;
    logic               ewr, ebusy;
    logic [DW-1:0]      edat;
    logic [GW-1:0]      egid;
    logic [15:0]        got, exp;
    logic [NREQ-1:0]    ack_s, oth;
    logic               wr_s;
    logic [GW-1:0]      gid_s;
    logic [DW-1:0]      dat_s;
    int                 g;

    for (int i = 0; i < NREQ; i++) begin
      if (hold[i])                 rq[i] = 1'b1;
      else if (phead[i] < ptail[i]) rq[i] = rand_gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      else                          rq[i] = 1'b0;
      rd[i*DW +: DW] = (phead[i] < ptail[i]) ? pmem[i][phead[i]] : 8'($urandom);
    end
    rst = r; full = f; req = rq; req_data = rd;

    ewr = 1'b0; eack = '0; ebusy = 1'b0; edat = '0; egid = '0;
    if (!r && m_cur >= 0) begin
      ewr   = rq[m_cur] && !f;
      if (ewr) eack[m_cur] = 1'b1;
      ebusy = 1'b1;
      egid  = GW'(m_cur);
      edat  = rd[m_cur*DW +: DW];
    end

    @(negedge wr_clk);
    got = {wr_en, ack, busy, grant_id, wr_data};
    exp = {ewr, eack, ebusy, egid, edat};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL cycle %0d outputs {wr_en,ack,busy,gid,data}: got %h, expected %h", cyc, got, exp);
    end
    ack_s = ack; wr_s = wr_en; gid_s = grant_id; dat_s = wr_data;

    if (wr_s === 1'b1) begin
      g = int'(gid_s);
      if (nlog < 256) begin
        wlog_id[nlog] = g; wlog_cyc[nlog] = cyc; wlog_dat[nlog] = dat_s;
      end
      nlog++;
      vectors++;
      if (shead[g] >= ptail[g]) begin
        miscompares++;
        $display("FAIL scoreboard: producer %0d wrote %h, expected no more words", g, dat_s);
      end else begin
        if (dat_s !== pmem[g][shead[g]]) begin
          miscompares++;
          $display("FAIL scoreboard: producer %0d wrote %h, expected %h", g, dat_s, pmem[g][shead[g]]);
        end
        shead[g]++;
      end
    end

    @(posedge wr_clk);
    for (int i = 0; i < NREQ; i++) begin
      if (ack_s[i] === 1'b1 && rq[i]) begin
        phead[i]++;
        hold[i] = 1'b0;
      end else begin
        hold[i] = rq[i];
      end
    end

    if (r) begin
      m_cur = -1; m_prev = NREQ - 1; m_taken = 0;
    end else if (m_cur < 0) begin
      if (|rq) begin m_cur = rr_next(m_prev, rq); m_taken = 0; end
    end else begin
      if (ewr) m_taken++;
      if (m_taken == MAXB || !rq[m_cur]) begin
        oth = rq; oth[m_cur] = 1'b0;
        m_prev  = m_cur;
        m_taken = 0;
        m_cur   = (|oth) ? rr_next(m_prev, oth) : -1;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic reset_seq();
    for (int i = 0; i < NREQ; i++) begin
      phead[i] = 0; ptail[i] = 0; shead[i] = 0; hold[i] = 1'b0;
    end
    rand_gaps = 1'b0;
    step_cycle(1'b1, 1'b0);
    step_cycle(1'b1, 1'b0);
    cyc = 0; nlog = 0;
  endtask

  task automatic load(input int i, input logic [7:0] d);
    pmem[i][ptail[i]] = d;
    ptail[i]++;
  endtask

  task automatic run_until(input int nw, input int maxc, input int rst_at,
                           input int f_from, input int f_to);
    int k;
    k = 0;
    while (nlog < nw && k < maxc) begin
      step_cycle(cyc == rst_at, (cyc >= f_from) && (cyc <= f_to));
      k++;
    end
    check("writes_within_budget", nlog, nw);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] got, exp;
    logic [DW-1:0] edat;
    int pending;

    m_cur = -1; m_prev = NREQ - 1; m_taken = 0;
    cyc = 0; nlog = 0;

    //            rst  req     full  wr_en ack     busy gid
    tbl[0]  = '{1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[1]  = '{1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[2]  = '{1'b0, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[3]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[4]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[5]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[6]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[7]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[8]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[9]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[10] = '{1'b0, 4'b1111, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[11] = '{1'b0, 4'b1001, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1};
    tbl[12] = '{1'b0, 4'b1001, 1'b0, 1'b1, 4'b1000, 1'b1, 2'd3};
    tbl[13] = '{1'b0, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd3};
    tbl[14] = '{1'b0, 4'b0001, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[15] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[16] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[17] = '{1'b0, 4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[18] = '{1'b0, 4'b0100, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[19] = '{1'b1, 4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[20] = '{1'b0, 4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[21] = '{1'b0, 4'b0100, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[22] = '{1'b0, 4'b0100, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd2};
    tbl[23] = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd2};
    tbl[24] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};

    rst = 1'b1; full = 1'b0; req = '0;
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    // Table-driven: reset, grant order, full stall, owner drop, mid-burst reset
    for (int v = 0; v < 25; v++) begin
      rst = tbl[v].rst; req = tbl[v].req; full = tbl[v].full;
      edat = tbl[v].busy ? (8'hA0 + {6'd0, tbl[v].gid}) : 8'h00;
      @(negedge wr_clk);
      got = {wr_en, ack, busy, grant_id, wr_data};
      exp = {tbl[v].wr_en, tbl[v].ack, tbl[v].busy, tbl[v].gid, edat};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL vector %0d {wr_en,ack,busy,gid,data}: got %h, expected %h", v, got, exp);
      end
      @(posedge wr_clk);
      #1;
    end

    // Single producer 2 streams 0x11..0x16: bursts of 4 and 2, one IDLE between
    reset_seq();
    for (int k = 0; k < 6; k++) load(2, 8'(8'h11 + k));
    run_until(6, 40, -1, -1, -1);
    for (int k = 0; k < 6; k++) begin
      check("single_cycle", wlog_cyc[k], exp2_cyc[k]);
      check("single_data", int'(wlog_dat[k]), 8'h11 + k);
      check("single_id", wlog_id[k], 2);
    end

    // All four requesting 8 words each: 4-word bursts 0,1,2,3,0,1,2,3 back to back
    reset_seq();
    for (int i = 0; i < NREQ; i++)
      for (int k = 0; k < 8; k++) load(i, 8'((i << 4) | k));
    run_until(32, 60, -1, -1, -1);
    for (int n = 0; n < 32; n++) begin
      check("rr_id", wlog_id[n], (n / 4) % 4);
      check("rr_data", int'(wlog_dat[n]), (((n / 4) % 4) << 4) | ((n / 16) * 4 + n % 4));
      check("rr_cycle", wlog_cyc[n], n + 1);
    end

    // full held for 3 cycles mid-burst: burst count frozen, no loss or duplicate
    reset_seq();
    for (int k = 0; k < 5; k++) load(1, 8'(8'h40 + k));
    run_until(5, 30, -1, 2, 4);
    for (int k = 0; k < 5; k++) begin
      check("stall_cycle", wlog_cyc[k], exp4_cyc[k]);
      check("stall_data", int'(wlog_dat[k]), 8'h40 + k);
    end

    // Reset pulse mid-burst: unacked word re-sent after re-grant, exactly once
    reset_seq();
    for (int k = 0; k < 3; k++) load(0, 8'(8'h60 + k));
    run_until(3, 30, 2, -1, -1);
    for (int k = 0; k < 3; k++) begin
      check("rst_cycle", wlog_cyc[k], exp6_cyc[k]);
      check("rst_data", int'(wlog_dat[k]), 8'h60 + k);
    end
    for (int k = 0; k < 3; k++) step_cycle(1'b0, 1'b0);
    check("rst_no_duplicate", nlog, 3);

    // Randomised traffic against the reference model
    reset_seq();
    for (int i = 0; i < NREQ; i++)
      for (int k = 0; k < 30; k++) load(i, 8'($urandom));
    rand_gaps = 1'b1;
    for (int c = 0; c < 700; c++)
      step_cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0);
    rand_gaps = 1'b0;
    for (int c = 0; c < 400; c++) begin
      pending = 0;
      for (int i = 0; i < NREQ; i++) if (phead[i] < ptail[i]) pending++;
      if (pending != 0) step_cycle(1'b0, 1'b0);
    end
    for (int i = 0; i < NREQ; i++) begin
      check("drain_written", shead[i], ptail[i]);
      check("drain_acked", phead[i], ptail[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
